// File: rtl/dp_ram_param_if.sv
// Request/response bundle for the two-port RAM with occupancy tracking.
// The master drives both request ports and the synchronous clear; the slave
// (the RAM) returns per-port read data and status pulses plus the occupancy.
interface dp_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              clear;

    logic              en_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] rdata_a;
    logic              rvalid_a;
    logic              wack_a;
    logic              err_a;

    logic              en_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid_b;
    logic              wack_b;
    logic              err_b;

    logic              coll;
    logic [ADDR_W:0]   used;
    logic              full;

    modport master (
        output clear,
        output en_a, we_a, addr_a, wdata_a,
        output en_b, we_b, addr_b, wdata_b,
        input  rdata_a, rvalid_a, wack_a, err_a,
        input  rdata_b, rvalid_b, wack_b, err_b,
        input  coll, used, full
    );

    modport slave (
        input  clear,
        input  en_a, we_a, addr_a, wdata_a,
        input  en_b, we_b, addr_b, wdata_b,
        output rdata_a, rvalid_a, wack_a, err_a,
        output rdata_b, rvalid_b, wack_b, err_b,
        output coll, used, full
    );
endinterface

// File: rtl/dp_ram_param.sv
// True dual-port RAM with per-entry valid bits, a quota on distinct written
// entries, deterministic same-address arbitration (port A wins, read-first)
// and registered per-port status pulses.
// Optional macro DPRAM_OUTREG_EN adds a second output register stage so that
// rdata/rvalid/wack/err/coll arrive two cycles after the request; used/full
// always reflect writes one cycle after the request.
module dp_ram_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 8,
    parameter int MAX_USED = DEPTH
) (
    input logic            clk,
    input logic            reset,
    dp_ram_param_if.slave  bus
);

    localparam logic [ADDR_W:0] MAX_CNT   = (ADDR_W+1)'(MAX_USED);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W:0]   used_q;

    logic              in_a, in_b;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic              same;
    logic              new_a, new_b, ok_a, ok_b, take_a, take_b;
    logic              store_a, store_b;
    logic [ADDR_W:0]   used_mid, used_next;
    logic [DATA_W-1:0] rword_a, rword_b;

    logic [DATA_W-1:0] rdata_a1, rdata_b1;
    logic              rvalid_a1, rvalid_b1, wack_a1, wack_b1, err_a1, err_b1, coll1;

    // Decode requests, resolve quota (A is charged before B) and collisions.
    // When both ports write one address only A's write counts, so the quota
    // charge is at most one and B simply inherits A's verdict.
    always_comb begin
        in_a     = {1'b0, bus.addr_a} < DEPTH_CNT;
        in_b     = {1'b0, bus.addr_b} < DEPTH_CNT;
        wr_a     = bus.en_a & bus.we_a & in_a;
        wr_b     = bus.en_b & bus.we_b & in_b;
        rd_a     = bus.en_a & ~bus.we_a & in_a;
        rd_b     = bus.en_b & ~bus.we_b & in_b;
        same     = wr_a & wr_b & (bus.addr_a == bus.addr_b);
        new_a    = wr_a & ~valid[bus.addr_a];
        ok_a     = ~new_a | (used_q < MAX_CNT);
        take_a   = new_a & ok_a;
        used_mid = used_q + {{ADDR_W{1'b0}}, take_a};
        new_b    = wr_b & ~valid[bus.addr_b] & ~same;
        ok_b     = same ? ok_a : (~new_b | (used_mid < MAX_CNT));
        take_b   = new_b & ok_b;
        used_next = used_mid + {{ADDR_W{1'b0}}, take_b};
        store_a  = wr_a & (bus.clear | ok_a);
        store_b  = wr_b & ~same & (bus.clear | ok_b);
        rword_a  = (~bus.clear & valid[bus.addr_a]) ? mem[bus.addr_a] : '0;
        rword_b  = (~bus.clear & valid[bus.addr_b]) ? mem[bus.addr_b] : '0;
    end

    // Storage array: never reset, written even during clear.
    always_ff @(posedge clk) begin
        if (store_a) mem[bus.addr_a] <= bus.wdata_a;
        if (store_b) mem[bus.addr_b] <= bus.wdata_b;
    end

    // Occupancy tracking: valid bits and used count, clear overrides writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= '0;
            used_q <= '0;
        end else if (bus.clear) begin
            valid  <= '0;
            used_q <= '0;
        end else begin
            if (take_a) valid[bus.addr_a] <= 1'b1;
            if (take_b) valid[bus.addr_b] <= 1'b1;
            used_q <= used_next;
        end
    end

    // First response stage: read data (held between reads) and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a1  <= '0;
            rdata_b1  <= '0;
            rvalid_a1 <= 1'b0;
            rvalid_b1 <= 1'b0;
            wack_a1   <= 1'b0;
            wack_b1   <= 1'b0;
            err_a1    <= 1'b0;
            err_b1    <= 1'b0;
            coll1     <= 1'b0;
        end else begin
            if (rd_a) rdata_a1 <= rword_a;
            if (rd_b) rdata_b1 <= rword_b;
            rvalid_a1 <= rd_a;
            rvalid_b1 <= rd_b;
            wack_a1   <= wr_a & ok_a & ~bus.clear;
            wack_b1   <= wr_b & ok_b & ~bus.clear;
            err_a1    <= bus.en_a & (~in_a | (wr_a & ~ok_a & ~bus.clear));
            err_b1    <= bus.en_b & (~in_b | (wr_b & ~ok_b & ~bus.clear));
            coll1     <= same;
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [DATA_W-1:0] rdata_a2, rdata_b2;
    logic              rvalid_a2, rvalid_b2, wack_a2, wack_b2, err_a2, err_b2, coll2;

    // Second response stage: delays every response by one more cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a2  <= '0;
            rdata_b2  <= '0;
            rvalid_a2 <= 1'b0;
            rvalid_b2 <= 1'b0;
            wack_a2   <= 1'b0;
            wack_b2   <= 1'b0;
            err_a2    <= 1'b0;
            err_b2    <= 1'b0;
            coll2     <= 1'b0;
        end else begin
            rdata_a2  <= rdata_a1;
            rdata_b2  <= rdata_b1;
            rvalid_a2 <= rvalid_a1;
            rvalid_b2 <= rvalid_b1;
            wack_a2   <= wack_a1;
            wack_b2   <= wack_b1;
            err_a2    <= err_a1;
            err_b2    <= err_b1;
            coll2     <= coll1;
        end
    end

    assign bus.rdata_a  = rdata_a2;
    assign bus.rdata_b  = rdata_b2;
    assign bus.rvalid_a = rvalid_a2;
    assign bus.rvalid_b = rvalid_b2;
    assign bus.wack_a   = wack_a2;
    assign bus.wack_b   = wack_b2;
    assign bus.err_a    = err_a2;
    assign bus.err_b    = err_b2;
    assign bus.coll     = coll2;
`else
    assign bus.rdata_a  = rdata_a1;
    assign bus.rdata_b  = rdata_b1;
    assign bus.rvalid_a = rvalid_a1;
    assign bus.rvalid_b = rvalid_b1;
    assign bus.wack_a   = wack_a1;
    assign bus.wack_b   = wack_b1;
    assign bus.err_a    = err_a1;
    assign bus.err_b    = err_b1;
    assign bus.coll     = coll1;
`endif

    assign bus.used = used_q;
    assign bus.full = (used_q == MAX_CNT);

endmodule

// File: tb/tb_dp_ram_param.sv
// Directed bench for dp_ram_param configured with DEPTH=6 (addresses 6 and 7
// are out of range) and MAX_USED=3 so quota, range and collision corners are
// all reachable in one instance. Honours DPRAM_OUTREG_EN for response latency.
module tb_dp_ram_param;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 6;
    localparam int MAX_USED = 3;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dp_ram_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dp_ram_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_USED(MAX_USED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setIdle();
        bus.clear   = 1'b0;
        bus.en_a    = 1'b0;
        bus.we_a    = 1'b0;
        bus.addr_a  = '0;
        bus.wdata_a = '0;
        bus.en_b    = 1'b0;
        bus.we_b    = 1'b0;
        bus.addr_b  = '0;
        bus.wdata_b = '0;
    endtask

    // Present one request cycle, then wait until its responses are visible.
    task automatic applyStimulus(input logic clr,
                                 input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                                 input logic eb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
        @(negedge clk);
        bus.clear   = clr;
        bus.en_a    = ea;
        bus.we_a    = wa;
        bus.addr_a  = aa;
        bus.wdata_a = da;
        bus.en_b    = eb;
        bus.we_b    = wb;
        bus.addr_b  = ab;
        bus.wdata_b = db;
        @(posedge clk);
        #1;
        setIdle();
        repeat (LAT-1) @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rdata_a", 64'(bus.rdata_a), 64'h0);
        checkOutput("rst_rdata_b", 64'(bus.rdata_b), 64'h0);
        checkOutput("rst_pulses", 64'({bus.rvalid_a, bus.rvalid_b, bus.wack_a, bus.wack_b,
                                       bus.err_a, bus.err_b, bus.coll}), 64'h0);
        checkOutput("rst_used", 64'(bus.used), 64'h0);
        checkOutput("rst_full", 64'(bus.full), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // A writes 0xA5 to addr 2, then reads it back
        applyStimulus(0, 1,1,3'd2,8'hA5, 0,0,3'd0,8'h00);
        checkOutput("w2_wack_a", 64'(bus.wack_a), 64'h1);
        checkOutput("w2_err_a", 64'(bus.err_a), 64'h0);
        checkOutput("w2_used", 64'(bus.used), 64'h1);
        applyStimulus(0, 1,0,3'd2,8'h00, 0,0,3'd0,8'h00);
        checkOutput("r2_rdata_a", 64'(bus.rdata_a), 64'hA5);
        checkOutput("r2_rvalid_a", 64'(bus.rvalid_a), 64'h1);
        checkOutput("r2_wack_a", 64'(bus.wack_a), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("r2_pulse_end", 64'(bus.rvalid_a), 64'h0);
        checkOutput("r2_hold", 64'(bus.rdata_a), 64'hA5);

        // B reads unwritten addr 5
        applyStimulus(0, 0,0,3'd0,8'h00, 1,0,3'd5,8'h00);
        checkOutput("r5_rdata_b", 64'(bus.rdata_b), 64'h0);
        checkOutput("r5_rvalid_b", 64'(bus.rvalid_b), 64'h1);
        checkOutput("r5_err_b", 64'(bus.err_b), 64'h0);

        // Quota: used 1 -> 2, then one slot left for two new writes
        applyStimulus(0, 1,1,3'd0,8'h10, 0,0,3'd0,8'h00);
        checkOutput("w0_used", 64'(bus.used), 64'h2);
        applyStimulus(0, 1,1,3'd4,8'h44, 1,1,3'd1,8'h55);
        checkOutput("q_wack_a", 64'(bus.wack_a), 64'h1);
        checkOutput("q_wack_b", 64'(bus.wack_b), 64'h0);
        checkOutput("q_err_a", 64'(bus.err_a), 64'h0);
        checkOutput("q_err_b", 64'(bus.err_b), 64'h1);
        checkOutput("q_used", 64'(bus.used), 64'h3);
        checkOutput("q_full", 64'(bus.full), 64'h1);
        applyStimulus(0, 1,1,3'd0,8'h11, 0,0,3'd0,8'h00);
        checkOutput("rw0_wack_a", 64'(bus.wack_a), 64'h1);
        checkOutput("rw0_err_a", 64'(bus.err_a), 64'h0);
        checkOutput("rw0_used", 64'(bus.used), 64'h3);
        applyStimulus(0, 1,0,3'd0,8'h00, 1,0,3'd1,8'h00);
        checkOutput("r0_rdata_a", 64'(bus.rdata_a), 64'h11);
        checkOutput("r1_rdata_b", 64'(bus.rdata_b), 64'h0);
        checkOutput("r1_rvalid_b", 64'(bus.rvalid_b), 64'h1);

        // Out of range: A reads 7, B writes 6
        applyStimulus(0, 1,0,3'd7,8'h00, 1,1,3'd6,8'h66);
        checkOutput("oor_err_a", 64'(bus.err_a), 64'h1);
        checkOutput("oor_rvalid_a", 64'(bus.rvalid_a), 64'h0);
        checkOutput("oor_rdata_a", 64'(bus.rdata_a), 64'h11);
        checkOutput("oor_err_b", 64'(bus.err_b), 64'h1);
        checkOutput("oor_wack_b", 64'(bus.wack_b), 64'h0);
        checkOutput("oor_used", 64'(bus.used), 64'h3);

        // clear with a concurrent A write and B read
        applyStimulus(1, 1,1,3'd3,8'h77, 1,0,3'd0,8'h00);
        checkOutput("clr_wack_a", 64'(bus.wack_a), 64'h0);
        checkOutput("clr_err_a", 64'(bus.err_a), 64'h0);
        checkOutput("clr_rvalid_b", 64'(bus.rvalid_b), 64'h1);
        checkOutput("clr_rdata_b", 64'(bus.rdata_b), 64'h0);
        checkOutput("clr_used", 64'(bus.used), 64'h0);
        checkOutput("clr_full", 64'(bus.full), 64'h0);
        applyStimulus(0, 1,0,3'd3,8'h00, 0,0,3'd0,8'h00);
        checkOutput("clr_r3_rdata_a", 64'(bus.rdata_a), 64'h0);
        checkOutput("clr_r3_rvalid_a", 64'(bus.rvalid_a), 64'h1);

        // Same-address write collision on addr 3
        applyStimulus(0, 1,1,3'd3,8'h11, 1,1,3'd3,8'h22);
        checkOutput("col_coll", 64'(bus.coll), 64'h1);
        checkOutput("col_wack", 64'({bus.wack_a, bus.wack_b}), 64'h3);
        checkOutput("col_used", 64'(bus.used), 64'h1);
        applyStimulus(0, 0,0,3'd0,8'h00, 1,0,3'd3,8'h00);
        checkOutput("col_r3_rdata_b", 64'(bus.rdata_b), 64'h11);
        checkOutput("col_coll_end", 64'(bus.coll), 64'h0);

        // Read-first: A overwrites addr 5 while B reads it
        applyStimulus(0, 1,1,3'd5,8'h33, 0,0,3'd0,8'h00);
        checkOutput("w5_used", 64'(bus.used), 64'h2);
        applyStimulus(0, 1,1,3'd5,8'h5A, 1,0,3'd5,8'h00);
        checkOutput("rf_rdata_b", 64'(bus.rdata_b), 64'h33);
        checkOutput("rf_wack_a", 64'(bus.wack_a), 64'h1);
        checkOutput("rf_used", 64'(bus.used), 64'h2);
        applyStimulus(0, 0,0,3'd0,8'h00, 1,0,3'd5,8'h00);
        checkOutput("rf_next_rdata_b", 64'(bus.rdata_b), 64'h5A);

        // Clear alone, then two new distinct writes in one cycle (+2)
        applyStimulus(1, 0,0,3'd0,8'h00, 0,0,3'd0,8'h00);
        checkOutput("clr2_used", 64'(bus.used), 64'h0);
        applyStimulus(0, 1,1,3'd0,8'h01, 1,1,3'd1,8'h02);
        checkOutput("dw_wack", 64'({bus.wack_a, bus.wack_b}), 64'h3);
        checkOutput("dw_used", 64'(bus.used), 64'h2);
        applyStimulus(0, 1,0,3'd1,8'h00, 1,0,3'd0,8'h00);
        checkOutput("dw_rdata_a", 64'(bus.rdata_a), 64'h02);
        checkOutput("dw_rdata_b", 64'(bus.rdata_b), 64'h01);

        // Reset asserted while a read is in flight
        @(negedge clk);
        bus.en_a   = 1'b1;
        bus.we_a   = 1'b0;
        bus.addr_a = 3'd1;
        @(posedge clk);
        #1;
        setIdle();
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_rvalid_a", 64'(bus.rvalid_a), 64'h0);
        checkOutput("mid_rst_rdata_a", 64'(bus.rdata_a), 64'h0);
        checkOutput("mid_rst_used", 64'(bus.used), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_rvalid_a", 64'(bus.rvalid_a), 64'h0);
        end
        applyStimulus(0, 1,0,3'd1,8'h00, 0,0,3'd0,8'h00);
        checkOutput("post_rst_r1_rdata_a", 64'(bus.rdata_a), 64'h0);
        checkOutput("post_rst_r1_rvalid_a", 64'(bus.rvalid_a), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
